econet_rx_buffer: RTL
=====================

# econet_rx_buffer

Downstream consumer of the Econet receive path. Takes the byte stream, frame delimiters and running FCS from the receiver/FCS pair, filters frames by destination station, and stores one accepted frame in an internal byte RAM. It checks the FCS residue, strips the two FCS bytes from the reported length, and holds the frame for the CPU-side reader until it is acknowledged.

## Interface
- ADDR_W, 9: RAM address width. Buffer depth is 2^ADDR_W bytes, FCS bytes included.
- MIN_LEN, 2: minimum payload bytes, excluding FCS. Shorter frames are silently dropped.
- GOOD_RESIDUE, 16'hF0B8: `rx_fcs` value that indicates a correct FCS after all bytes, including both FCS bytes.
- econet_clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- rx_byte  in  8  received byte, valid when `rx_byte_ready` is high.
- rx_byte_ready  in  1  one-cycle byte strobe.
- rx_frame_start  in  1  one-cycle pulse at the opening flag.
- rx_frame_end  in  1  one-cycle pulse at the closing flag.
- rx_fcs  in  16  running FCS. Updated the cycle after each `rx_byte_ready`.
- my_station  in  8  local station number.
- promisc  in  1  when high, accept all destinations.
- rd_addr  in  ADDR_W  CPU read address.
- rd_data  out  8  RAM byte at `rd_addr`, one cycle latency.
- frame_ready  out  1  a frame is held for reading.
- frame_len  out  ADDR_W+1  payload length, total bytes minus 2.
- frame_ok  out  1  FCS good and no overflow.
- too_long  out  1  frame exceeded the buffer.
- overrun  out  1  sticky; a frame start arrived while a frame was held.
- frame_ack  in  1  one-cycle pulse that releases the held frame.

## Operation
- States: IDLE, RECV, DISCARD, CHECK, HOLD. Reset enters IDLE.
- Reset values: all outputs 0; byte count 0.
- IDLE:
  - `rx_frame_start` → RECV; count cleared.
- RECV, on each `rx_byte_ready`:
  - If count < 2^ADDR_W, write `rx_byte` to RAM[count].
  - Otherwise set the internal overflow bit and do not write.
  - Count increments, saturating at 2^ADDR_W + 1.
- RECV, address filter on byte 0:
  - If `promisc` = 0 and `rx_byte` ≠ `my_station` and `rx_byte` ≠ 8'hFF → DISCARD.
- RECV, other events:
  - `rx_frame_start` → restart RECV, count cleared, overflow cleared; the partial frame is lost.
  - `rx_frame_end` → CHECK.
- DISCARD:
  - Ignores bytes and `rx_frame_end`.
  - `rx_frame_start` → RECV.
- CHECK (exactly one cycle):
  - If count < MIN_LEN+2 → IDLE, no flags.
  - Otherwise latch `frame_len` = count−2 (when overflowed, `frame_len` = 2^ADDR_W − 2), `too_long` = overflow, `frame_ok` = (`rx_fcs` == GOOD_RESIDUE) && !overflow → HOLD.
- HOLD:
  - `frame_ready` = 1; RAM is not written.
  - `rx_frame_start` sets `overrun`; bytes and `rx_frame_end` are ignored.
  - `frame_ack` → IDLE; clears `frame_ready`, `frame_ok`, `too_long` and `overrun`. `frame_len` keeps its value.
  - `frame_ack` together with `rx_frame_start` → RECV; `overrun` is not set.
- `frame_ack` outside HOLD: ignored.
- RAM: single write port (RECV), single registered read port. `rd_data` is valid in every state; the held frame is stable only in HOLD.

## Timing
- `rx_frame_end` at cycle T (state RECV):
  - CHECK at T+1, where `rx_fcs` is sampled.
  - `frame_ready`, `frame_ok`, `frame_len`, `too_long` registered, valid from T+2.
- Upstream guarantees ≥1 cycle between the last `rx_byte_ready` and `rx_frame_end`, so `rx_fcs` is final at T+1.
- `rx_byte_ready` and `rx_frame_end` in the same cycle: the byte is written and counted, then CHECK.
- `rx_frame_start` and `rx_byte_ready` in the same cycle in RECV: restart takes priority; the byte becomes byte 0 of the new frame.
- `rd_addr` at cycle N → `rd_data` at N+1.
- `frame_ack` at cycle N → `frame_ready` low at N+1. The earliest new write is the first `rx_byte_ready` after a start accepted at ≥N.
- Reset assertion at any time: immediate return to IDLE with outputs cleared. RAM contents are undefined.

## Test plan
- Accepted frame: `my_station` = 8'h05, frame 05 00 01 00 80 99 plus correct FCS, then end → `frame_ready` at T+2, `frame_len` = 6, `frame_ok` = 1, `rd_data` at addr 0..5 matches; `frame_ack` → `frame_ready` 0.
- Filtering: destination 8'h07 with `promisc` = 0 → no `frame_ready`. Same frame with `promisc` = 1 → accepted. Destination 8'hFF → accepted.
- Bad FCS: flip one bit in the last FCS byte → `frame_ready` = 1, `frame_ok` = 0, `too_long` = 0. Runt of 3 bytes → no `frame_ready`.
- Overflow with ADDR_W = 4: 20-byte frame → `too_long` = 1, `frame_ok` = 0, `frame_len` = 14, RAM[0..15] = first 16 bytes.
- Overrun: while in HOLD, send a complete second frame → `overrun` = 1, first frame data unchanged; `frame_ack` clears `overrun`. `frame_ack` coincident with `rx_frame_start` → next frame received, `overrun` = 0.
- Abort and reset: `rx_frame_start` mid-frame after 3 bytes, then a good 6-byte frame → `frame_len` = 6, data from the second frame only. Reset pulled low while in HOLD → all outputs 0 asynchronously.

Source files
------------

// File: rtl/econet_rx_buffer_if.sv
// Byte stream from the Econet receiver/FCS pair into the receive buffer.
interface econet_rx_buffer_if;
  logic [7:0]  rx_byte;
  logic        rx_byte_ready;
  logic        rx_frame_start;
  logic        rx_frame_end;
  logic [15:0] rx_fcs;

  modport master (output rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rx_fcs);
  modport slave  (input  rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rx_fcs);
endinterface

// File: rtl/econet_rx_buffer.sv
// Econet receive buffer: filters by destination station, stores one frame in RAM,
// checks the FCS residue and holds the frame until the CPU acknowledges it.
module econet_rx_buffer #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned MIN_LEN      = 2,
  parameter logic [15:0] GOOD_RESIDUE = 16'hF0B8
) (
  input  logic              econet_clk,
  input  logic              reset,
  econet_rx_buffer_if.slave rx,
  input  logic [7:0]        my_station,
  input  logic              promisc,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_ok,
  output logic              too_long,
  output logic              overrun,
  input  logic              frame_ack
);
  localparam int unsigned     DEPTH_N   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] TWO       = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] CNT_MAX   = DEPTH + ONE;
  localparam logic [ADDR_W:0] MIN_TOTAL = (ADDR_W+1)'(MIN_LEN + 2);

  typedef enum logic [2:0] {IDLE, RECV, DISCARD, CHECK, HOLD} state_t;

  state_t              state, next_state;
  logic [ADDR_W:0]     count;
  logic                overflow;
  logic                addr_miss;
  logic                wr_en;
  logic [ADDR_W:0]     wr_index;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          mem [DEPTH_N];

  // State register
  always_ff @(posedge econet_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  assign addr_miss = !promisc && (rx.rx_byte != my_station) && (rx.rx_byte != 8'hFF);

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (rx.rx_frame_start) next_state = RECV;
      RECV: begin
        if (rx.rx_byte_ready && wr_index == '0 && addr_miss) next_state = DISCARD;
        else if (!rx.rx_frame_start && rx.rx_frame_end)      next_state = CHECK;
      end
      DISCARD: if (rx.rx_frame_start) next_state = RECV;
      CHECK:   next_state = (count < MIN_TOTAL) ? IDLE : HOLD;
      HOLD:    if (frame_ack) next_state = rx.rx_frame_start ? RECV : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output / write-port logic; a restart coinciding with a byte lands it at index 0
  always_comb begin
    wr_index    = rx.rx_frame_start ? '0 : count;
    wr_en       = (state == RECV) && rx.rx_byte_ready && (wr_index < DEPTH);
    wr_addr     = wr_index[ADDR_W-1:0];
    frame_ready = (state == HOLD);
  end

  always_ff @(posedge econet_clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      frame_len <= '0;
      frame_ok  <= 1'b0;
      too_long  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE, DISCARD: begin
          if (rx.rx_frame_start) begin
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        RECV: begin
          if (rx.rx_frame_start) begin
            count    <= rx.rx_byte_ready ? ONE : '0;
            overflow <= 1'b0;
          end else if (rx.rx_byte_ready) begin
            if (count >= DEPTH)   overflow <= 1'b1;
            if (count != CNT_MAX) count    <= count + ONE;
          end
        end
        CHECK: begin
          if (count >= MIN_TOTAL) begin
            frame_len <= overflow ? (DEPTH - TWO) : (count - TWO);
            too_long  <= overflow;
            frame_ok  <= (rx.rx_fcs == GOOD_RESIDUE) && !overflow;
          end
        end
        HOLD: begin
          if (frame_ack) begin
            frame_ok <= 1'b0;
            too_long <= 1'b0;
            overrun  <= 1'b0;
            count    <= '0;
            overflow <= 1'b0;
          end else if (rx.rx_frame_start) begin
            overrun  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge econet_clk) begin
    if (wr_en) mem[wr_addr] <= rx.rx_byte;
  end

  always_ff @(posedge econet_clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end
endmodule
